// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: drives datapath selects, strobes and ALU op.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a HALT state with illegal=1.
module multicycle_controller #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       pos,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_cntr,
    output logic [2:0] imm_src,
    output logic       illegal
);

    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EX_R, EX_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
        MEM_WR, BRANCH, JAL, JALR_ADR, JALR_PC, LUI
`ifdef CTRL_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic       pc_write_q, pc_write_d;
    logic       adr_src_d, mem_write_d, ir_write_d, reg_write_d;
    logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d;
    logic [2:0] alu_cntr_d;
    logic       illegal_d;
    logic       br_take;

    // Only func7[5] selects sub; the remaining funct7 bits carry no control meaning here.
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  alu_op = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            FETCH: begin
                if (cnt == CNT_W'(FETCH_WAIT)) begin
                    state_d = DECODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DECODE: begin
                case (opc)
                    OP_R:          state_d = EX_R;
                    OP_I:          state_d = EX_I;
                    OP_LW, OP_SW:  state_d = MEM_ADR;
                    OP_BR:         state_d = BRANCH;
                    OP_JAL:        state_d = JAL;
                    OP_JALR:       state_d = JALR_ADR;
                    OP_LUI:        state_d = LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:       state_d = HALT;
`else
                    default:       state_d = FETCH;
`endif
                endcase
            end
            EX_R, EX_I:           state_d = ALU_WB;
            MEM_ADR:              state_d = opc[5] ? MEM_WR : MEM_RD;
            MEM_RD:               state_d = MEM_WB;
            JAL, JALR_PC:         state_d = ALU_WB;
            JALR_ADR:             state_d = JALR_PC;
            ALU_WB, MEM_WB, MEM_WR, BRANCH, LUI: state_d = FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            HALT:                 state_d = HALT;
`endif
            default:              state_d = IDLE;
        endcase
    end

    // Controls for the state being entered, so they can leave the flops with the state itself
    always_comb begin
        pc_write_d   = 1'b0;
        adr_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_write_d  = 1'b0;
        result_src_d = 2'b00;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_cntr_d   = ALU_ADD;
        illegal_d    = 1'b0;
        case (state_d)
            FETCH: begin
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
                if (cnt_d == CNT_W'(FETCH_WAIT)) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                end
            end
            DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            EX_R: begin
                alu_src_a_d = 2'b10;
                alu_cntr_d  = alu_op(func3, func7[5]);
            end
            EX_I: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_cntr_d  = alu_op(func3, 1'b0);
            end
            ALU_WB:  reg_write_d = 1'b1;
            MEM_ADR, JALR_ADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            MEM_RD:  adr_src_d = 1'b1;
            MEM_WB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            MEM_WR: begin
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            BRANCH: begin
                alu_src_a_d = 2'b10;
                alu_cntr_d  = ALU_SUB;
            end
            JAL, JALR_PC: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_write_d  = 1'b1;
            end
            LUI: begin
                result_src_d = 2'b11;
                reg_write_d  = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            HALT:    illegal_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pc_write_q <= 1'b0;
            adr_src    <= 1'b0;
            mem_write  <= 1'b0;
            ir_write   <= 1'b0;
            reg_write  <= 1'b0;
            result_src <= 2'b00;
            alu_src_a  <= 2'b00;
            alu_src_b  <= 2'b00;
            alu_cntr   <= 3'b000;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pc_write_q <= pc_write_d;
            adr_src    <= adr_src_d;
            mem_write  <= mem_write_d;
            ir_write   <= ir_write_d;
            reg_write  <= reg_write_d;
            result_src <= result_src_d;
            alu_src_a  <= alu_src_a_d;
            alu_src_b  <= alu_src_b_d;
            alu_cntr   <= alu_cntr_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal <= 1'b0;
        else      illegal <= illegal_d;
    end
`else
    assign illegal = 1'b0;
    logic unused_illegal;
    assign unused_illegal = illegal_d;
`endif

    // Branch decision uses the live ALU flags of the subtract in BRANCH
    always_comb begin
        br_take = 1'b0;
        if (state == BRANCH) begin
            case (func3)
                3'b000:  br_take = zero;
                3'b001:  br_take = !zero;
                3'b100:  br_take = !zero && !pos;
                3'b101:  br_take = zero || pos;
                default: br_take = 1'b0;
            endcase
        end
    end

    assign pc_write = pc_write_q | br_take;

    always_comb begin
        case (opc)
            OP_SW:   imm_src = 3'b001;
            OP_BR:   imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b011;
            OP_LUI:  imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors from an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [2:0] imm;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opc = 7'b0110011;
    logic [2:0] func3 = 3'b000;
    logic [6:0] func7 = 7'b0000000;
    logic       zero = 1'b0;
    logic       pos = 1'b0;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_cntr, imm_src;
    logic       pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2;
    logic [2:0] alu_cntr2, imm_src2;

    int errors = 0;
    int checks = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .rst(rst), .opc(opc), .func3(func3), .func7(func7), .zero(zero), .pos(pos),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_cntr(alu_cntr), .imm_src(imm_src), .illegal(illegal)
    );

    multicycle_controller #(.FETCH_WAIT(2)) u_dut2 (
        .clk(clk), .rst(rst), .opc(opc), .func3(func3), .func7(func7), .zero(zero), .pos(pos),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
        .reg_write(reg_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_cntr(alu_cntr2), .imm_src(imm_src2), .illegal(illegal2)
    );

    function automatic ctl_t obs(input int sel);
        ctl_t c;
        if (sel == 1)
            c = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_cntr, imm_src, illegal};
        else
            c = {pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, result_src2,
                 alu_src_a2, alu_src_b2, alu_cntr2, imm_src2, illegal2};
        return c;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    // ALU operation named by an R/I-type funct3 (sub only when requested)
    function automatic logic [2:0] op_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'd1 : 3'd0;
            3'b111:  return 3'd2;
            3'b110:  return 3'd3;
            3'b100:  return 3'd5;
            3'b010:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Branch outcome from the signed difference rs1-rs2
    function automatic logic taken_of(input logic [2:0] f3, input int d);
        case (f3)
            3'b000:  return d == 0;
            3'b001:  return d != 0;
            3'b100:  return d < 0;
            3'b101:  return d >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input ctl_t o, input ctl_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected control vector for every cycle of one instruction, fetch included
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input int d, input int fw);
        ctl_t b, c, wb;
        b = '0;
        b.imm = imm_of(o);
        wb = b; wb.rw = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= fw; i++) begin
            c = b; c.sb = 2'b10; c.rs = 2'b10;
            if (i == fw) begin c.irw = 1'b1; c.pcw = 1'b1; end
            exp_q.push_back(c);
        end
        c = b; c.sa = 2'b01; c.sb = 2'b01; exp_q.push_back(c);
        case (o)
            7'b0110011: begin
                c = b; c.sa = 2'b10; c.alu = op_of(f3, f7[5]); exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            7'b0010011: begin
                c = b; c.sa = 2'b10; c.sb = 2'b01; c.alu = op_of(f3, 1'b0); exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            7'b0000011, 7'b0100011: begin
                c = b; c.sa = 2'b10; c.sb = 2'b01; exp_q.push_back(c);
                c = b; c.adr = 1'b1;
                if (o[5]) begin
                    c.mw = 1'b1; exp_q.push_back(c);
                end else begin
                    exp_q.push_back(c);
                    c = wb; c.rs = 2'b01; exp_q.push_back(c);
                end
            end
            7'b1100011: begin
                c = b; c.sa = 2'b10; c.alu = 3'd1; c.pcw = taken_of(f3, d); exp_q.push_back(c);
            end
            7'b1101111: begin
                c = b; c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            7'b1100111: begin
                c = b; c.sa = 2'b10; c.sb = 2'b01; exp_q.push_back(c);
                c = b; c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            7'b0110111: begin
                c = wb; c.rs = 2'b11; exp_q.push_back(c);
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                c = b; c.ill = 1'b1;
                for (int i = 0; i < 10; i++) exp_q.push_back(c);
`endif
            end
        endcase
    endtask

    // Called #1 after the edge that enters FETCH; checks at most max_cyc cycles
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input int d, input int sel, input int fw,
                             input int max_cyc);
        int n;
        build(o, f3, f7, d, fw);
        opc = o; func3 = f3; func7 = f7; zero = (d == 0); pos = (d > 0);
        n = 0;
        foreach (exp_q[i]) begin
            if (n >= max_cyc) break;
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, i), obs(sel), exp_q[i]);
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic reset_seq(input int sel);
        ctl_t z;
        z = '0; z.imm = imm_of(opc);
        rst = 1'b0; #1;
        check("reset_low", obs(sel), z);
        @(negedge clk);
        rst = 1'b1;
        check("idle", obs(sel), z);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] o;
        logic [2:0] f3;
        logic [6:0] f7;
        int d, nops;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};
`ifdef CTRL_ILLEGAL_TRAP_EN
        nops = 8;
`else
        nops = 9;
`endif
        #2;
        reset_seq(1);
        run_instr("add_part", 7'b0110011, 3'b000, 7'b0000000, 1, 1, 0, 2);
        #2;
        reset_seq(1);

        run_instr("add",   7'b0110011, 3'b000, 7'b0000000, 1, 1, 0, 99);
        run_instr("sub",   7'b0110011, 3'b000, 7'b0100000, 1, 1, 0, 99);
        run_instr("xori",  7'b0010011, 3'b100, 7'b0100000, 1, 1, 0, 99);
        run_instr("addi",  7'b0010011, 3'b000, 7'b0100000, 1, 1, 0, 99);
        run_instr("lw",    7'b0000011, 3'b010, 7'b0000000, 1, 1, 0, 99);
        run_instr("sw",    7'b0100011, 3'b010, 7'b0000000, 1, 1, 0, 99);
        run_instr("beq_t", 7'b1100011, 3'b000, 7'b0000000, 0, 1, 0, 99);
        run_instr("beq_n", 7'b1100011, 3'b000, 7'b0000000, 5, 1, 0, 99);
        run_instr("blt_t", 7'b1100011, 3'b100, 7'b0000000, -3, 1, 0, 99);
        run_instr("bge_t", 7'b1100011, 3'b101, 7'b0000000, 7, 1, 0, 99);
        run_instr("jal",   7'b1101111, 3'b000, 7'b0000000, 1, 1, 0, 99);
        run_instr("jalr",  7'b1100111, 3'b000, 7'b0000000, 1, 1, 0, 99);
        run_instr("lui",   7'b0110111, 3'b000, 7'b0000000, 1, 1, 0, 99);

        for (int k = 0; k < 40; k++) begin
            o  = ops[$urandom_range(0, nops - 1)];
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom_range(0, 127));
            d  = $urandom_range(0, 4) - 2;
            run_instr($sformatf("rnd%0d", k), o, f3, f7, d, 1, 0, 99);
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_instr("halt", 7'b1111111, 3'b000, 7'b0000000, 1, 1, 0, 99);
        reset_seq(1);
`else
        run_instr("nop", 7'b1111111, 3'b000, 7'b0000000, 1, 1, 0, 99);
        run_instr("after_nop", 7'b0110011, 3'b111, 7'b0000000, 1, 1, 0, 99);
`endif

        reset_seq(2);
        run_instr("fw2_jalr", 7'b1100111, 3'b000, 7'b0000000, 1, 2, 2, 99);
        run_instr("fw2_sw",   7'b0100011, 3'b010, 7'b0000000, 1, 2, 2, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
